// File: rtl/sr_register_bank_pkg.sv
// Shared definitions for the set/clear register bank: conflict-resolution modes
// and the mode type used by each channel cell.
package sr_bank_pkg;

    typedef enum logic [1:0] {
        SR_MODE_HOLD = 2'd0,
        SR_MODE_SET  = 2'd1,
        SR_MODE_CLR  = 2'd2,
        SR_MODE_TGL  = 2'd3
    } sr_mode_e;

    localparam int unsigned SR_MODE_MAX = 3;

endpackage : sr_bank_pkg

// File: rtl/sr_register_bank_cell.sv
// One set/clear channel: registered state plus registered rise/fall pulses.
// q_next exposes the value q takes on the coming edge, for bank-level change detection.
module sr_cell
    import sr_bank_pkg::*;
#(
    parameter sr_mode_e MODE    = SR_MODE_HOLD,
    parameter logic     RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic set,
    input  logic clr,
    input  logic load,
    input  logic d,
    output logic q,
    output logic rose,
    output logic fell,
    output logic q_next
);

    logic r_q;
    logic r_rose;
    logic r_fell;
    logic w_q_next;

    always_comb begin
        w_q_next = r_q;
        if (load) begin
            w_q_next = d;
        end else if (en) begin
            case ({set, clr})
                2'b10:   w_q_next = 1'b1;
                2'b01:   w_q_next = 1'b0;
                2'b11: begin
                    case (MODE)
                        SR_MODE_SET: w_q_next = 1'b1;
                        SR_MODE_CLR: w_q_next = 1'b0;
                        SR_MODE_TGL: w_q_next = ~r_q;
                        default:     w_q_next = r_q;
                    endcase
                end
                default: w_q_next = r_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q    <= RST_VAL;
            r_rose <= 1'b0;
            r_fell <= 1'b0;
        end else begin
            r_q    <= w_q_next;
            r_rose <= ~r_q & w_q_next;
            r_fell <= r_q & ~w_q_next;
        end
    end

    assign q      = r_q;
    assign rose   = r_rose;
    assign fell   = r_fell;
    assign q_next = w_q_next;

endmodule : sr_cell

// File: rtl/sr_register_bank.sv
// Bank of WIDTH sticky set/clear flags with edge pulses and a conflict flag.
// Define SR_BANK_EVT_CNT_EN to add the saturating evt_cnt change counter.
module sr_register_bank
    import sr_bank_pkg::*;
#(
    parameter int unsigned      WIDTH   = 4,
    parameter int unsigned      MODE    = 0,
    parameter logic [WIDTH-1:0] RST_VAL = '0,
    parameter int unsigned      CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] set,
    input  logic [WIDTH-1:0] clr,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] rose,
    output logic [WIDTH-1:0] fell,
    output logic             conflict
`ifdef SR_BANK_EVT_CNT_EN
    ,
    output logic [CNT_W-1:0] evt_cnt
`endif
);

    if (MODE > SR_MODE_MAX) begin : g_bad_mode
        $error("sr_register_bank: MODE must be 0..3");
    end
    if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
        $error("sr_register_bank: WIDTH must be 1..32");
    end
    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("sr_register_bank: CNT_W must be at least 1");
    end

    localparam sr_mode_e LP_MODE = sr_mode_e'(MODE[1:0]);

    logic r_conflict;

`ifdef SR_BANK_EVT_CNT_EN
    logic [WIDTH-1:0] w_q_next;
`endif

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        sr_cell #(
            .MODE    (LP_MODE),
            .RST_VAL (RST_VAL[i])
        ) u_cell (
            .clk    (clk),
            .rst    (rst),
            .en     (en),
            .set    (set[i]),
            .clr    (clr[i]),
            .load   (load),
            .d      (d[i]),
            .q      (q[i]),
            .rose   (rose[i]),
            .fell   (fell[i]),
`ifdef SR_BANK_EVT_CNT_EN
            .q_next (w_q_next[i])
`else
            .q_next ()
`endif
        );
    end

    // Flags contention regardless of how MODE resolved it; a load overrides the request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_conflict <= 1'b0;
        end else begin
            r_conflict <= (|(set & clr)) & en & ~load;
        end
    end

    assign conflict = r_conflict;

`ifdef SR_BANK_EVT_CNT_EN
    logic [CNT_W-1:0] r_evt_cnt;
    logic             w_changed;

    assign w_changed = |(w_q_next ^ q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_evt_cnt <= '0;
        end else if (w_changed && (r_evt_cnt != {CNT_W{1'b1}})) begin
            r_evt_cnt <= r_evt_cnt + 1'b1;
        end
    end

    assign evt_cnt = r_evt_cnt;
`endif

endmodule : sr_register_bank

// File: tb/tb_sr_register_bank.sv
// Directed bench: four banks (MODE 0..3) share stimulus; expected values are hand-derived.
module tb_sr_register_bank;

    logic       clk;
    logic       rst;
    logic       en;
    logic [3:0] set;
    logic [3:0] clr;
    logic       load;
    logic [3:0] d;

    logic [3:0] q    [4];
    logic [3:0] rose [4];
    logic [3:0] fell [4];
    logic       conf [4];
`ifdef SR_BANK_EVT_CNT_EN
    logic [1:0] cnt  [4];
`endif

    int n_vec;
    int n_err;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        sr_register_bank #(
            .WIDTH   (4),
            .MODE    (g),
            .RST_VAL (4'b0000),
            .CNT_W   (2)
        ) u_dut (
            .clk      (clk),
            .rst      (rst),
            .en       (en),
            .set      (set),
            .clr      (clr),
            .load     (load),
            .d        (d),
            .q        (q[g]),
            .rose     (rose[g]),
            .fell     (fell[g]),
            .conflict (conf[g])
`ifdef SR_BANK_EVT_CNT_EN
            ,
            .evt_cnt  (cnt[g])
`endif
        );
    end

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // drive on the falling edge, sample 1 time unit after the rising edge
    task automatic drive(input logic t_en, input logic [3:0] t_set, input logic [3:0] t_clr,
                         input logic t_load, input logic [3:0] t_d);
        @(negedge clk);
        en   = t_en;
        set  = t_set;
        clr  = t_clr;
        load = t_load;
        d    = t_d;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst  = 1'b1;
        en   = 1'b0;
        set  = '0;
        clr  = '0;
        load = 1'b0;
        d    = '0;
        repeat (2) @(posedge clk);
        #1;
        check_vec("rst_q",    {28'd0, q[0]},    32'h0);
        check_vec("rst_rose", {28'd0, rose[0]}, 32'h0);
        check_vec("rst_conf", {31'd0, conf[0]}, 32'h0);

        // load 1010 then reset mid-cycle
        @(negedge clk);
        rst = 1'b0;
        drive(1'b0, 4'b0000, 4'b0000, 1'b1, 4'b1010);
        tick();
        check_vec("load_q",    {28'd0, q[0]},    32'hA);
        check_vec("load_rose", {28'd0, rose[0]}, 32'hA);
        #2 rst = 1'b1;
        #1;
        check_vec("async_rst_q",    {28'd0, q[0]},    32'h0);
        check_vec("async_rst_rose", {28'd0, rose[0]}, 32'h0);
        check_vec("async_rst_fell", {28'd0, fell[0]}, 32'h0);
`ifdef SR_BANK_EVT_CNT_EN
        check_vec("async_rst_cnt", {30'd0, cnt[0]}, 32'h0);
`endif
        drive(1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0000);
        rst = 1'b0;
        tick();
        check_vec("rel_q", {28'd0, q[0]}, 32'h0);

        // basic set / clr / repeated set
        drive(1'b1, 4'b0011, 4'b0000, 1'b0, 4'b0000);
        tick();
        check_vec("set_q",    {28'd0, q[0]},    32'h3);
        check_vec("set_rose", {28'd0, rose[0]}, 32'h3);
        check_vec("set_conf", {31'd0, conf[0]}, 32'h0);
        drive(1'b1, 4'b0000, 4'b0001, 1'b0, 4'b0000);
        tick();
        check_vec("clr_q",    {28'd0, q[0]},    32'h2);
        check_vec("clr_fell", {28'd0, fell[0]}, 32'h1);
        check_vec("clr_rose", {28'd0, rose[0]}, 32'h0);
        drive(1'b1, 4'b0010, 4'b0000, 1'b0, 4'b0000);
        tick();
        check_vec("reset_q",    {28'd0, q[0]},    32'h2);
        check_vec("reset_rose", {28'd0, rose[0]}, 32'h0);

        // load 0101 from 0010
        drive(1'b0, 4'b0000, 4'b0000, 1'b1, 4'b0101);
        tick();
        check_vec("ld5_q",    {28'd0, q[0]},    32'h5);
        check_vec("ld5_rose", {28'd0, rose[0]}, 32'h5);
        check_vec("ld5_fell", {28'd0, fell[0]}, 32'h2);

        // conflict on all channels, per mode
        drive(1'b1, 4'b1111, 4'b1111, 1'b0, 4'b0000);
        tick();
        check_vec("m0_q",    {28'd0, q[0]}, 32'h5);
        check_vec("m1_q",    {28'd0, q[1]}, 32'hF);
        check_vec("m2_q",    {28'd0, q[2]}, 32'h0);
        check_vec("m3_q",    {28'd0, q[3]}, 32'hA);
        check_vec("m1_rose", {28'd0, rose[1]}, 32'hA);
        check_vec("m2_fell", {28'd0, fell[2]}, 32'h5);
        check_vec("m0_conf", {31'd0, conf[0]}, 32'h1);
        check_vec("m3_conf", {31'd0, conf[3]}, 32'h1);
        tick();
        check_vec("m3_q2",    {28'd0, q[3]},    32'h5);
        check_vec("m3_rose2", {28'd0, rose[3]}, 32'h5);
        check_vec("m3_fell2", {28'd0, fell[3]}, 32'hA);
        check_vec("m0_q2",    {28'd0, q[0]},    32'h5);
        check_vec("m2_conf2", {31'd0, conf[2]}, 32'h1);

        // enable low: set ignored, conflict cleared
        drive(1'b0, 4'b1111, 4'b1111, 1'b0, 4'b0000);
        tick();
        check_vec("en0_q",    {28'd0, q[0]},    32'h5);
        check_vec("en0_rose", {28'd0, rose[0]}, 32'h0);
        check_vec("en0_conf", {31'd0, conf[0]}, 32'h0);

        // load beats en/clr
        drive(1'b1, 4'b0000, 4'b1111, 1'b1, 4'b1001);
        tick();
        check_vec("ldp_q",     {28'd0, q[0]},    32'h9);
        check_vec("ldp_rose",  {28'd0, rose[0]}, 32'h8);
        check_vec("ldp_fell",  {28'd0, fell[0]}, 32'h4);
        check_vec("ldp_conf",  {31'd0, conf[0]}, 32'h0);
        check_vec("ldp_m1_f",  {28'd0, fell[1]}, 32'h6);
        check_vec("ldp_m1_r",  {28'd0, rose[1]}, 32'h0);

        // toggle run for the event counter
        drive(1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0000);
        rst = 1'b1;
        #1;
        rst = 1'b0;
        drive(1'b1, 4'b0001, 4'b0001, 1'b0, 4'b0000);
        for (int k = 0; k < 4; k++) begin
            logic [3:0] exp_q;
            logic [1:0] exp_c;
            exp_q = (k % 2 == 0) ? 4'b0001 : 4'b0000;
            exp_c = (k < 3) ? 2'(k + 1) : 2'd3;
            tick();
            check_vec($sformatf("tgl_q%0d", k), {28'd0, q[3]}, {28'd0, exp_q});
`ifdef SR_BANK_EVT_CNT_EN
            check_vec($sformatf("cnt%0d", k), {30'd0, cnt[3]}, {30'd0, exp_c});
`else
            if (exp_c == 2'd0) $display("unexpected counter model value");
`endif
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_sr_register_bank

// File: doc/sr_register_bank.md
# sr_register_bank

Parametrised bank of WIDTH independent set/clear flip-flop channels, the multi-channel successor to the single-bit SR flip-flop. It adds a selectable conflict-resolution mode (hold, set-wins, clear-wins, toggle), clock enable, parallel load, and registered edge-event pulses. It sits between control/status logic and consumers that need sticky flags with change notification.

## Interface
- WIDTH, 4, number of channels (1..32)
- MODE, 0, response to set&clr on one channel: 0 hold, 1 set wins, 2 clear wins, 3 toggle
- RST_VAL, '0, WIDTH-bit value of q after reset
- CNT_W, 8, width of evt_cnt (only with SR_BANK_EVT_CNT_EN)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- en  in  1  clock enable for set/clr updates
- set  in  WIDTH  per-channel set request
- clr  in  WIDTH  per-channel clear request
- load  in  1  parallel load strobe
- d  in  WIDTH  parallel load data
- q  out  WIDTH  channel state
- rose  out  WIDTH  one-cycle pulse: channel went 0->1 on this edge
- fell  out  WIDTH  one-cycle pulse: channel went 1->0 on this edge
- conflict  out  1  high for one cycle after an edge where any channel had set&clr with en=1
- evt_cnt  out  CNT_W  saturating count of edges on which q changed (macro only)

## Operation
- Reset (async, any time, including mid-load): q=RST_VAL, rose=0, fell=0, conflict=0, evt_cnt=0. Release takes effect at the next rising edge; no pulses generated by reset itself.
- Priority per edge: load > en-gated set/clr > hold.
- load=1: q<=d regardless of en, set, clr; conflict<=0.
- load=0, en=1, per channel i: set only -> 1; clr only -> 0; neither -> hold; both -> per MODE (0 hold, 1 -> 1, 2 -> 0, 3 -> ~q[i]).
- load=0, en=0: q holds; set/clr ignored; conflict<=0.
- rose[i] <= ~q_old[i] & q_new[i]; fell[i] <= q_old[i] & ~q_new[i]; computed for every edge including load.
- conflict <= |(set & clr) & en & ~load, independent of MODE.
- Illegal MODE (>3): elaboration error.

## Timing
- Latency: inputs sampled at edge N; q, rose, fell, conflict valid after edge N. No combinational input-to-output path.
- rose/fell/conflict are single-cycle unless the condition recurs on the next edge (MODE 3 with set&clr held toggles q every edge: rose and fell alternate every cycle).
- Re-asserting set on a channel already 1 produces no rose pulse.

## Configuration
- SR_BANK_EVT_CNT_EN defined: evt_cnt port and counter present; increments by 1 on each edge where q_new != q_old (any number of channels counts once); saturates at 2^CNT_W-1; cleared only by rst.
- Undefined: evt_cnt port absent, no counter logic; all other behaviour identical.

## Structure
- Package sr_bank_pkg: mode constants SR_MODE_HOLD=0, SR_MODE_SET=1, SR_MODE_CLR=2, SR_MODE_TGL=3, and a mode type.
- Sub-module sr_cell: one channel (q, rose, fell; inputs clk, rst, en, set, clr, load, d); instantiated WIDTH times by generate. conflict and evt_cnt live in the top level.

## Test plan
- Reset mid-operation: q=4'b1010 via load, assert rst between edges -> q=RST_VAL (4'b0000) immediately, rose=fell=0, evt_cnt=0.
- Basic set/clr, en=1, MODE=0: set=4'b0011 -> q=4'b0011, rose=4'b0011; next clr=4'b0001 -> q=4'b0010, fell=4'b0001; repeat set=4'b0010 -> no rose.
- Conflict per mode from q=4'b0101, set=clr=4'b1111: MODE0 -> q=4'b0101; MODE1 -> 4'b1111; MODE2 -> 4'b0000; MODE3 -> 4'b1010 then 4'b0101 next edge; conflict=1 each case.
- Enable/load priority: en=0, set=4'b1111 -> q holds, conflict=0; load=1, d=4'b1001, clr=4'b1111, en=1 -> q=4'b1001, conflict=0, rose/fell reflect load.
- Counter saturation (macro on, CNT_W=2, MODE3, set=clr=4'b0001 held) -> evt_cnt 1,2,3,3; macro off build has no evt_cnt port and other outputs match.
